raster_walker: RTL and testbench

RASTER_WALKER -- requirements
Module: raster_walker

---
 rtl/raster_pkg.sv | 28 ++
 rtl/raster_weight.sv | 33 +++
 rtl/raster_walker.sv | 222 ++++++++++++++++++++++
 tb/tb_raster_walker.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared state encoding and width helpers for the raster walker.
package raster_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, WALK, DRAIN} rw_state_e;

    localparam int XW_DEF = 10;
    localparam int YW_DEF = 10;
    localparam int DW_DEF = 8;
    localparam int ZW_DEF = 7;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Edge accumulators must hold coordinate-delta times edge-delta products plus sums.
    function automatic int edge_w(input int cw, input int dw);
        return 2*dw + cw + 2;
    endfunction

    function automatic int wgt_w(input int dw);
        return 2*dw + 2;
    endfunction

    function automatic int sum_w(input int dw);
        return 2*dw + 3;
    endfunction

endpackage

// File: rtl/raster_weight.sv
// Perspective-weighted barycentrics for one visible pixel (combinational).
module raster_weight #(
    parameter int EW = 28,
    parameter int ZW = 7,
    parameter int WW = 18
) (
    input  logic signed [EW-1:0] u,
    input  logic signed [EW-1:0] v,
    input  logic signed [EW-1:0] w,
    input  logic [ZW-1:0]        bz,
    input  logic [ZW-1:0]        cz,
    output logic [WW-1:0]        uw,
    output logic [WW-1:0]        vw,
    output logic [WW-1:0]        ww,
    output logic [WW:0]          aw
);

    // Only visible pixels are weighted, so u/v/w are non-negative here.
    logic [EW+ZW-1:0] vp, wp;
    logic             unused_bits;

    assign vp = {{ZW{1'b0}}, v} * {{EW{1'b0}}, bz};
    assign wp = {{ZW{1'b0}}, w} * {{EW{1'b0}}, cz};

    assign uw = u[WW:1];
    assign vw = vp[ZW +: WW];
    assign ww = wp[ZW +: WW];
    assign aw = {1'b0, uw} + {1'b0, vw} + {1'b0, ww};

    assign unused_bits = ^{u[EW-1:WW+1], u[0], vp[ZW-1:0], vp[EW+ZW-1:ZW+WW],
                           wp[ZW-1:0], wp[EW+ZW-1:ZW+WW]};

endmodule

// File: rtl/raster_walker.sv
// Bounding-box triangle walker: incremental edge functions, one pixel per cycle,
// two-stage fragment pipeline with backpressure.
module raster_walker
    import raster_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF,
    parameter int DW = DW_DEF,
    parameter int ZW = ZW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tri_valid,
    output logic                 tri_ready,
    input  logic [XW-1:0]        ax,
    input  logic [YW-1:0]        ay,
    input  logic signed [DW-1:0] abx,
    input  logic signed [DW-1:0] aby,
    input  logic signed [DW-1:0] acx,
    input  logic signed [DW-1:0] acy,
    input  logic [ZW-1:0]        bz,
    input  logic [ZW-1:0]        cz,
    input  logic [XW-1:0]        bx0,
    input  logic [YW-1:0]        by0,
    input  logic [XW-1:0]        bx1,
    input  logic [YW-1:0]        by1,
    output logic                 frag_valid,
    input  logic                 frag_ready,
    output logic [XW-1:0]        frag_x,
    output logic [YW-1:0]        frag_y,
    output logic [2*DW+1:0]      frag_uw,
    output logic [2*DW+1:0]      frag_vw,
    output logic [2*DW+1:0]      frag_ww,
    output logic [2*DW+2:0]      frag_aw,
    output logic                 tri_done
);

    localparam int CW     = max_w(XW, YW);
    localparam int EW     = edge_w(CW, DW);
    localparam int WW     = wgt_w(DW);
    localparam int AW     = sum_w(DW);
    localparam int STAGES = 1;

    typedef logic signed [EW-1:0] edge_t;

    typedef struct packed {
        logic [XW-1:0] ax;
        logic [YW-1:0] ay;
        logic [DW-1:0] abx;
        logic [DW-1:0] aby;
        logic [DW-1:0] acx;
        logic [DW-1:0] acy;
        logic [ZW-1:0] bz;
        logic [ZW-1:0] cz;
        logic [XW-1:0] bx0;
        logic [YW-1:0] by0;
        logic [XW-1:0] bx1;
        logic [YW-1:0] by1;
    } tri_t;

    rw_state_e         state;
    tri_t              tri_q;
    edge_t             v_q, w_q, abs_q, dvx_q, dwx_q, rowv_q, roww_q;
    logic [XW:0]       xc;
    logic [YW:0]       yc;
    logic [STAGES:0]   vld_pipe;
    logic              stall, issue, vis, last_x, last_y;
    edge_t             u_c;

    // Setup arithmetic, evaluated from the captured triangle
    edge_t abx_e, aby_e, acx_e, acy_e, apx_e, apy_e, sa_e, abs_e;
    edge_t v0_e, w0_e, dvx_e, dwx_e, rowv_e, roww_e, span_e;
    logic  s_pos;

    always_comb begin
        abx_e  = EW'($signed(tri_q.abx));
        aby_e  = EW'($signed(tri_q.aby));
        acx_e  = EW'($signed(tri_q.acx));
        acy_e  = EW'($signed(tri_q.acy));
        apx_e  = EW'($signed({1'b0, tri_q.bx0})) - EW'($signed({1'b0, tri_q.ax}));
        apy_e  = EW'($signed({1'b0, tri_q.by0})) - EW'($signed({1'b0, tri_q.ay}));
        sa_e   = abx_e * acy_e - aby_e * acx_e;
        s_pos  = !sa_e[EW-1] && (sa_e != '0);
        abs_e  = s_pos ? sa_e : -sa_e;
        v0_e   = apx_e * acy_e - apy_e * acx_e;
        w0_e   = abx_e * apy_e - aby_e * apx_e;
        if (!s_pos) begin
            v0_e = -v0_e;
            w0_e = -w0_e;
        end
        dvx_e  = s_pos ? acy_e : -acy_e;
        dwx_e  = s_pos ? -aby_e : aby_e;
        span_e = EW'({1'b0, tri_q.bx1 - tri_q.bx0});
        // Row step: one y step, then undo the span of x steps taken on this row
        rowv_e = (s_pos ? -acx_e : acx_e) - span_e * dvx_e;
        roww_e = (s_pos ? abx_e : -abx_e) - span_e * dwx_e;
    end

    assign stall  = vld_pipe[STAGES] && !frag_ready;
    assign issue  = (state == WALK) && !stall;
    assign u_c    = abs_q - v_q - w_q;
    assign vis    = !u_c[EW-1] && !v_q[EW-1] && !w_q[EW-1];
    assign last_x = (xc == {1'b0, tri_q.bx1});
    assign last_y = (yc == {1'b0, tri_q.by1});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tri_ready <= 1'b1;
            tri_done  <= 1'b0;
            tri_q     <= '0;
            v_q       <= '0;
            w_q       <= '0;
            abs_q     <= '0;
            dvx_q     <= '0;
            dwx_q     <= '0;
            rowv_q    <= '0;
            roww_q    <= '0;
            xc        <= '0;
            yc        <= '0;
        end else begin
            tri_done <= 1'b0;
            case (state)
                IDLE: if (tri_valid && tri_ready) begin
                    tri_q     <= '{ax: ax, ay: ay, abx: abx, aby: aby, acx: acx, acy: acy,
                                   bz: bz, cz: cz, bx0: bx0, by0: by0, bx1: bx1, by1: by1};
                    tri_ready <= 1'b0;
                    state     <= SETUP;
                end
                SETUP: begin
                    v_q    <= v0_e;
                    w_q    <= w0_e;
                    abs_q  <= abs_e;
                    dvx_q  <= dvx_e;
                    dwx_q  <= dwx_e;
                    rowv_q <= rowv_e;
                    roww_q <= roww_e;
                    xc     <= {1'b0, tri_q.bx0};
                    yc     <= {1'b0, tri_q.by0};
                    state  <= (sa_e == '0) ? DRAIN : WALK;
                end
                WALK: if (!stall) begin
                    if (last_x && last_y) begin
                        state <= DRAIN;
                    end else if (last_x) begin
                        xc  <= {1'b0, tri_q.bx0};
                        yc  <= yc + 1'b1;
                        v_q <= v_q + rowv_q;
                        w_q <= w_q + roww_q;
                    end else begin
                        xc  <= xc + 1'b1;
                        v_q <= v_q + dvx_q;
                        w_q <= w_q + dwx_q;
                    end
                end
                DRAIN: if (vld_pipe == '0) begin
                    tri_done  <= 1'b1;
                    tri_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [XW-1:0] s1_x;
    logic [YW-1:0] s1_y;
    edge_t         s1_u, s1_v, s1_w;
    logic [WW-1:0] uw_c, vw_c, ww_c;
    logic [AW-1:0] aw_c;

    raster_weight #(.EW(EW), .ZW(ZW), .WW(WW)) u_weight (
        .u  (s1_u),
        .v  (s1_v),
        .w  (s1_w),
        .bz (tri_q.bz),
        .cz (tri_q.cz),
        .uw (uw_c),
        .vw (vw_c),
        .ww (ww_c),
        .aw (aw_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_u     <= '0;
            s1_v     <= '0;
            s1_w     <= '0;
            frag_x   <= '0;
            frag_y   <= '0;
            frag_uw  <= '0;
            frag_vw  <= '0;
            frag_ww  <= '0;
            frag_aw  <= '0;
        end else if (!stall) begin
            vld_pipe[0] <= issue && vis;
            if (issue && vis) begin
                s1_x <= xc[XW-1:0];
                s1_y <= yc[YW-1:0];
                s1_u <= u_c;
                s1_v <= v_q;
                s1_w <= w_q;
            end
            vld_pipe[STAGES] <= vld_pipe[0];
            // Output register only loads real fragments so it stays put between them
            if (vld_pipe[0]) begin
                frag_x  <= s1_x;
                frag_y  <= s1_y;
                frag_uw <= uw_c;
                frag_vw <= vw_c;
                frag_ww <= ww_c;
                frag_aw <= aw_c;
            end
        end
    end

    assign frag_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_raster_walker.sv
// Randomized scoreboard bench for raster_walker against a direct edge-function model.
module tb_raster_walker;

    localparam int XW = 10;
    localparam int YW = 10;
    localparam int DW = 8;
    localparam int ZW = 7;
    localparam int WW = 2*DW+2;
    localparam int AW = 2*DW+3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                 tri_valid, tri_ready, frag_valid, frag_ready, tri_done;
    logic [XW-1:0]        ax, bx0, bx1, frag_x;
    logic [YW-1:0]        ay, by0, by1, frag_y;
    logic signed [DW-1:0] abx, aby, acx, acy;
    logic [ZW-1:0]        bz, cz;
    logic [WW-1:0]        frag_uw, frag_vw, frag_ww;
    logic [AW-1:0]        frag_aw;

    raster_walker #(.XW(XW), .YW(YW), .DW(DW), .ZW(ZW)) dut (
        .clk(clk), .rst_n(rst_n), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .ax(ax), .ay(ay), .abx(abx), .aby(aby), .acx(acx), .acy(acy),
        .bz(bz), .cz(cz), .bx0(bx0), .by0(by0), .bx1(bx1), .by1(by1),
        .frag_valid(frag_valid), .frag_ready(frag_ready),
        .frag_x(frag_x), .frag_y(frag_y), .frag_uw(frag_uw), .frag_vw(frag_vw),
        .frag_ww(frag_ww), .frag_aw(frag_aw), .tri_done(tri_done)
    );

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [WW-1:0] uw;
        logic [WW-1:0] vw;
        logic [WW-1:0] ww;
        logic [AW-1:0] aw;
    } frag_s;

    typedef struct {
        int ax, ay, abx, aby, acx, acy, bz, cz, x0, y0, x1, y1;
    } cfg_t;

    frag_s  exp_q[$];
    frag_s  first_frag, held;
    int     vectors = 0;
    int     miscompares = 0;
    int     tri_frag_cnt = 0;
    int     done_cnt = 0;
    int     stall_obs = 0;
    int     bp_mode = 0;
    int     hold_cnt = 0;
    bit     hold_used = 0;
    bit     have_hold = 0;
    longint t_acc, t_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: evaluate the edge functions directly at every box pixel.
    task automatic model(input cfg_t c, output int cnt);
        longint sa, a, v, w, u, vwt, wwt;
        frag_s  f;
        cnt = 0;
        sa = longint'(c.abx) * c.acy - longint'(c.aby) * c.acx;
        if (sa == 0) return;
        a = (sa > 0) ? sa : -sa;
        for (int y = c.y0; y <= c.y1; y++) begin
            for (int x = c.x0; x <= c.x1; x++) begin
                v = longint'(x - c.ax) * c.acy - longint'(y - c.ay) * c.acx;
                w = longint'(c.abx) * (y - c.ay) - longint'(c.aby) * (x - c.ax);
                if (sa < 0) begin
                    v = -v;
                    w = -w;
                end
                u = a - v - w;
                if (u >= 0 && v >= 0 && w >= 0) begin
                    vwt  = (v * c.bz) / 128;
                    wwt  = (w * c.cz) / 128;
                    f.x  = XW'(x);
                    f.y  = YW'(y);
                    f.uw = WW'(u / 2);
                    f.vw = WW'(vwt);
                    f.ww = WW'(wwt);
                    f.aw = AW'(u / 2 + vwt + wwt);
                    exp_q.push_back(f);
                    cnt++;
                end
            end
        end
    endtask

    task automatic drive_cfg(input cfg_t c);
        ax  = XW'(c.ax);  ay  = YW'(c.ay);
        abx = DW'(c.abx); aby = DW'(c.aby); acx = DW'(c.acx); acy = DW'(c.acy);
        bz  = ZW'(c.bz);  cz  = ZW'(c.cz);
        bx0 = XW'(c.x0);  by0 = YW'(c.y0); bx1 = XW'(c.x1); by1 = YW'(c.y1);
    endtask

    task automatic send(input cfg_t c);
        int n = 0;
        @(posedge clk); #1;
        drive_cfg(c);
        tri_frag_cnt = 0;
        tri_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!tri_ready && n < 50);
        if (!tri_ready) begin
            miscompares++;
            $display("FAIL accept: tri_ready stayed %0d, expected 1", tri_ready);
        end
        @(posedge clk);
        t_acc = $time;
        #1 tri_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cnt);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == start) begin
            miscompares++;
            $display("FAIL %s_timeout: tri_done not seen in %0d cycles, expected 1 pulse", name, n);
        end
        repeat (6) @(posedge clk);
        chk({name, "_done_once"}, 64'(done_cnt - start), 64'd1);
        chk({name, "_frag_cnt"}, 64'(tri_frag_cnt), 64'(exp_cnt));
        chk({name, "_leftover"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic run_tri(input string name, input cfg_t c, output int cnt);
        model(c, cnt);
        send(c);
        wait_done(name, cnt);
    endtask

    // Monitor/scoreboard
    initial begin
        frag_s cur, e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_hold = 0;
                continue;
            end
            cur = '{frag_x, frag_y, frag_uw, frag_vw, frag_ww, frag_aw};
            if (have_hold) begin
                vectors++;
                stall_obs++;
                if (frag_valid !== 1'b1 || cur !== held) begin
                    miscompares++;
                    $display("FAIL stall_hold: got v=%0d (%0d,%0d) aw=%0d expected v=1 (%0d,%0d) aw=%0d",
                             frag_valid, cur.x, cur.y, cur.aw, held.x, held.y, held.aw);
                end
            end
            have_hold = frag_valid && !frag_ready;
            if (have_hold) held = cur;
            if (frag_valid && frag_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_frag: got (%0d,%0d) aw=%0d expected none", cur.x, cur.y, cur.aw);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        miscompares++;
                        $display("FAIL frag: got (%0d,%0d) uw=%0d vw=%0d ww=%0d aw=%0d expected (%0d,%0d) uw=%0d vw=%0d ww=%0d aw=%0d",
                                 cur.x, cur.y, cur.uw, cur.vw, cur.ww, cur.aw,
                                 e.x, e.y, e.uw, e.vw, e.ww, e.aw);
                    end
                end
                if (tri_frag_cnt == 0) first_frag = cur;
                tri_frag_cnt++;
            end
            if (tri_done === 1'b1) begin
                done_cnt++;
                t_done = $time;
            end
        end
    end

    // Downstream ready driver
    initial begin
        frag_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_cnt > 0) begin
                frag_ready = 1'b0;
                hold_cnt--;
            end else if (bp_mode == 2 && !hold_used && frag_valid && tri_frag_cnt == 2) begin
                frag_ready = 1'b0;
                hold_cnt = 4;
                hold_used = 1;
            end else if (bp_mode == 1) begin
                frag_ready = ($urandom_range(0, 3) != 0);
            end else begin
                frag_ready = 1'b1;
            end
        end
    end

    initial begin
        cfg_t c, big, g;
        int   cnt, lat, d0, tmp;
        tri_valid = 1'b0;
        c = '{10, 10, 4, 0, 0, 4, 64, 64, 10, 10, 14, 14};
        drive_cfg(c);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_frag_valid", 64'(frag_valid), 64'd0);
        chk("rst_tri_done", 64'(tri_done), 64'd0);
        chk("rst_frag_x", 64'(frag_x), 64'd0);
        chk("rst_frag_aw", 64'(frag_aw), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tri_ready", 64'(tri_ready), 64'd1);

        // Basic triangle, with ignored tri_valid pulses mid-walk
        model(c, cnt);
        send(c);
        repeat (4) @(posedge clk);
        #1;
        g = '{3, 7, -50, 20, 33, -9, 5, 9, 0, 0, 3, 3};
        drive_cfg(g);
        tri_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1 tri_valid = 1'b0;
        wait_done("basic", cnt);
        chk("basic_count", 64'(tri_frag_cnt), 64'd15);
        chk("basic_first_x", 64'(first_frag.x), 64'd10);
        chk("basic_first_y", 64'(first_frag.y), 64'd10);
        chk("basic_first_uw", 64'(first_frag.uw), 64'd8);
        chk("basic_first_vw", 64'(first_frag.vw), 64'd0);
        chk("basic_first_aw", 64'(first_frag.aw), 64'd8);

        // Negative winding
        c = '{10, 10, 0, 4, 4, 0, 64, 64, 10, 10, 14, 14};
        run_tri("negwind", c, cnt);
        chk("negwind_count", 64'(tri_frag_cnt), 64'd15);

        // Degenerate
        c = '{10, 10, 2, 2, 4, 4, 64, 64, 10, 10, 14, 14};
        run_tri("degen", c, cnt);
        lat = int'((t_done - t_acc) / 10);
        vectors++;
        if (lat < 2 || lat > 4) begin
            miscompares++;
            $display("FAIL degen_latency: got %0d cycles expected 2..4", lat);
        end

        // Backpressure on the third fragment
        bp_mode = 2;
        hold_used = 0;
        stall_obs = 0;
        c = '{10, 10, 4, 0, 0, 4, 64, 64, 10, 10, 14, 14};
        run_tri("stall", c, cnt);
        vectors++;
        if (stall_obs < 4) begin
            miscompares++;
            $display("FAIL stall_seen: got %0d held cycles expected >= 4", stall_obs);
        end
        bp_mode = 0;

        // Corner pixel at maximum coordinates
        c = '{1020, 1020, 8, 0, 0, 8, 64, 64, 1023, 1023, 1023, 1023};
        run_tri("corner", c, cnt);
        chk("corner_count", 64'(tri_frag_cnt), 64'd1);
        chk("corner_x", 64'(first_frag.x), 64'd1023);
        chk("corner_vw", 64'(first_frag.vw), 64'd12);
        chk("corner_aw", 64'(first_frag.aw), 64'd32);

        // Reset in the middle of a walk
        big = '{100, 100, 40, 0, 0, 40, 64, 64, 100, 100, 131, 131};
        model(big, cnt);
        send(big);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_frag_valid", 64'(frag_valid), 64'd0);
        exp_q.delete();
        d0 = done_cnt;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_tri_ready", 64'(tri_ready), 64'd1);
        repeat (5) @(posedge clk);
        chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        c = '{10, 10, 4, 0, 0, 4, 64, 64, 10, 10, 14, 14};
        run_tri("postrst", c, cnt);

        // Randomized triangles with random backpressure
        bp_mode = 1;
        for (int t = 0; t < 24; t++) begin
            c.x0 = int'($urandom_range(0, 1016));
            c.y0 = int'($urandom_range(0, 1016));
            c.x1 = c.x0 + ((t % 6 == 5) ? 0 : int'($urandom_range(0, 7)));
            c.y1 = c.y0 + ((t % 6 == 5) ? 0 : int'($urandom_range(0, 7)));
            tmp  = c.x0 + int'($urandom_range(0, 8)) - 4;
            c.ax = (tmp < 0) ? 0 : (tmp > 1023 ? 1023 : tmp);
            tmp  = c.y0 + int'($urandom_range(0, 8)) - 4;
            c.ay = (tmp < 0) ? 0 : (tmp > 1023 ? 1023 : tmp);
            if (t % 4 == 0) begin
                c.abx = int'($urandom_range(0, 255)) - 128;
                c.aby = int'($urandom_range(0, 255)) - 128;
                c.acx = int'($urandom_range(0, 255)) - 128;
                c.acy = int'($urandom_range(0, 255)) - 128;
            end else begin
                c.abx = int'($urandom_range(0, 40)) - 20;
                c.aby = int'($urandom_range(0, 40)) - 20;
                c.acx = int'($urandom_range(0, 40)) - 20;
                c.acy = int'($urandom_range(0, 40)) - 20;
            end
            c.bz = int'($urandom_range(0, 127));
            c.cz = int'($urandom_range(0, 127));
            run_tri("rand", c, cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
